// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the memory pipeline stage and its window RAM.
package mem_stage_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WB_REQ,
      ST_WB_XFER,
      ST_FILL_REQ,
      ST_FILL_XFER
   } mem_state_t;

   localparam int NCH_DEF      = 3;
   localparam int DW_DEF       = 16;
   localparam int TW_DEF       = 5;
   localparam int AW_DEF       = 25;
   localparam int WIN_LOG2_DEF = 8;
   localparam int WIN          = 1 << WIN_LOG2_DEF;

   function automatic int win_bytes(input int log2);
      return 1 << log2;
   endfunction

endpackage

// File: rtl/mem_stage_win_if.sv
// Transfer port between the memory stage (master) and the SDRAM controller (slave).
interface mem_stage_win_if #(
   parameter int AW = 25
);
   logic          sd_req;
   logic          sd_wr;
   logic [AW-1:0] sd_start_addr;
   logic [AW-1:0] sd_length;
   logic          sd_busy;
   logic          sd_rd_valid;
   logic [7:0]    sd_rd_data;
   logic          sd_wr_ready;
   logic [7:0]    sd_wr_data;
   logic          sd_done;

   modport master (
      output sd_req, sd_wr, sd_start_addr, sd_length, sd_wr_data,
      input  sd_busy, sd_rd_valid, sd_rd_data, sd_wr_ready, sd_done
   );

   modport slave (
      input  sd_req, sd_wr, sd_start_addr, sd_length, sd_wr_data,
      output sd_busy, sd_rd_valid, sd_rd_data, sd_wr_ready, sd_done
   );
endinterface

// File: rtl/mem_stage_win_dmem.sv
// Single-port byte RAM holding the cached window; synchronous write, combinational read.
module dmem_window #(
   parameter int AWIN = 8
) (
   input  logic            i_clk,
   input  logic            i_we,
   input  logic [AWIN-1:0] i_addr,
   input  logic [7:0]      i_wdata,
   output logic [7:0]      o_rdata
);

   logic [7:0] r_mem [0:(1<<AWIN)-1];

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_stage_win.sv
// Memory pipeline stage: registers pass-through channels and serves byte loads/stores
// from a local window RAM, swapping the window with SDRAM on a miss.
module mem_stage_win
   import mem_stage_pkg::*;
#(
   parameter int NCH      = NCH_DEF,
   parameter int DW       = DW_DEF,
   parameter int TW       = TW_DEF,
   parameter int AW       = AW_DEF,
   parameter int WIN_LOG2 = WIN_LOG2_DEF
) (
   input  logic              ref_clk,
   input  logic              rst,
   input  logic [NCH*DW-1:0] pt_data_in,
   input  logic [NCH*TW-1:0] pt_tag_in,
   output logic [NCH*DW-1:0] pt_data_out,
   output logic [NCH*TW-1:0] pt_tag_out,
   input  logic              ls_valid,
   input  logic              ls_R_nW,
   input  logic [AW-1:0]     ls_addr,
   input  logic [7:0]        ls_data,
   input  logic [TW-1:0]     ls_tag,
   output logic [TW-1:0]     ls_tag_out,
   output logic [7:0]        wb_data,
   output logic              stall,
   mem_stage_win_if.master   sdif
);

   localparam int WIN_M = win_bytes(WIN_LOG2);
   localparam int CW    = WIN_LOG2 + 1;
   localparam int BW    = AW - WIN_LOG2;

   mem_state_t r_state, w_state_nxt;
   logic [CW-1:0]       r_cnt;
   logic                r_win_valid, r_win_dirty;
   logic [BW-1:0]       r_win_base;
   logic [NCH*DW-1:0]   r_pt_data_p1;
   logic [NCH*TW-1:0]   r_pt_tag_p1;
   logic [7:0]          r_wb_data_p1;
   logic [TW-1:0]       r_ls_tag_p1;

   logic                w_hit, w_stall, w_cnt_full, w_store_hit, w_fill_we, w_ram_we, w_xfer_end;
   logic [WIN_LOG2-1:0] w_offset, w_ram_addr;
   logic [7:0]          w_ram_wdata, w_rdata;

   assign w_offset    = ls_addr[WIN_LOG2-1:0];
   assign w_hit       = r_win_valid && (ls_addr[AW-1:WIN_LOG2] == r_win_base);
   assign w_cnt_full  = (r_cnt == CW'(WIN_M));
   assign w_xfer_end  = sdif.sd_done && w_cnt_full;
   assign w_store_hit = (r_state == ST_IDLE) && ls_valid && w_hit && !ls_R_nW;
   assign w_fill_we   = (r_state == ST_FILL_XFER) && sdif.sd_rd_valid && !w_cnt_full;
   assign w_ram_we    = !rst && (w_store_hit || w_fill_we);
   // The single RAM port follows the access offset in IDLE and the transfer count otherwise.
   assign w_ram_addr  = (r_state == ST_IDLE) ? w_offset : r_cnt[WIN_LOG2-1:0];
   assign w_ram_wdata = (r_state == ST_IDLE) ? ls_data : sdif.sd_rd_data;

   dmem_window #(.AWIN(WIN_LOG2)) u_dmem (
      .i_clk   (ref_clk),
      .i_we    (w_ram_we),
      .i_addr  (w_ram_addr),
      .i_wdata (w_ram_wdata),
      .o_rdata (w_rdata)
   );

   // State register plus counter and window status
   always_ff @(posedge ref_clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_win_valid <= 1'b0;
         r_win_dirty <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            ST_IDLE: begin
               if (w_store_hit) r_win_dirty <= 1'b1;
            end
            ST_WB_REQ: begin
               if (!sdif.sd_busy) r_cnt <= '0;
            end
            ST_WB_XFER: begin
               if (sdif.sd_wr_ready && !w_cnt_full) r_cnt <= r_cnt + CW'(1);
               if (w_xfer_end) r_win_dirty <= 1'b0;
            end
            ST_FILL_REQ: begin
               if (!sdif.sd_busy) begin
                  r_cnt       <= '0;
                  r_win_valid <= 1'b0;
               end
            end
            ST_FILL_XFER: begin
               if (w_fill_we) r_cnt <= r_cnt + CW'(1);
               if (w_xfer_end) r_win_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge ref_clk) begin
      if (r_state == ST_FILL_XFER && w_xfer_end) r_win_base <= ls_addr[AW-1:WIN_LOG2];
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:      if (ls_valid && !w_hit) w_state_nxt = r_win_dirty ? ST_WB_REQ : ST_FILL_REQ;
         ST_WB_REQ:    if (!sdif.sd_busy) w_state_nxt = ST_WB_XFER;
         ST_WB_XFER:   if (w_xfer_end) w_state_nxt = ST_FILL_REQ;
         ST_FILL_REQ:  if (!sdif.sd_busy) w_state_nxt = ST_FILL_XFER;
         ST_FILL_XFER: if (w_xfer_end) w_state_nxt = ST_IDLE;
         default:      w_state_nxt = ST_IDLE;
      endcase
   end

   // Transfer-port and stall outputs
   always_comb begin
      w_stall            = (r_state != ST_IDLE) || (ls_valid && !w_hit);
      sdif.sd_req        = 1'b0;
      sdif.sd_wr         = 1'b0;
      sdif.sd_start_addr = '0;
      sdif.sd_wr_data    = '0;
      case (r_state)
         ST_WB_REQ: begin
            sdif.sd_req        = !sdif.sd_busy;
            sdif.sd_wr         = 1'b1;
            sdif.sd_start_addr = {r_win_base, {WIN_LOG2{1'b0}}};
         end
         ST_WB_XFER: begin
            sdif.sd_wr      = 1'b1;
            sdif.sd_wr_data = w_rdata;
         end
         ST_FILL_REQ: begin
            sdif.sd_req        = !sdif.sd_busy;
            sdif.sd_start_addr = {ls_addr[AW-1:WIN_LOG2], {WIN_LOG2{1'b0}}};
         end
         default: ;
      endcase
   end

   assign sdif.sd_length = AW'(WIN_M);
   assign stall          = w_stall;

   // Stage boundary: MEM -> WB registers, bubbles while stalled
   always_ff @(posedge ref_clk) begin
      if (rst || w_stall) begin
         r_pt_data_p1 <= '0;
         r_pt_tag_p1  <= '0;
         r_wb_data_p1 <= '0;
         r_ls_tag_p1  <= '0;
      end else begin
         r_pt_data_p1 <= pt_data_in;
         r_pt_tag_p1  <= pt_tag_in;
         if (ls_valid && ls_R_nW) begin
            r_wb_data_p1 <= w_rdata;
            r_ls_tag_p1  <= ls_tag;
         end else begin
            r_wb_data_p1 <= '0;
            r_ls_tag_p1  <= '0;
         end
      end
   end

   assign pt_data_out = r_pt_data_p1;
   assign pt_tag_out  = r_pt_tag_p1;
   assign wb_data     = r_wb_data_p1;
   assign ls_tag_out  = r_ls_tag_p1;

endmodule

// File: tb/tb_mem_stage_win.sv
// Directed bench for mem_stage_win: pass-through, window hits, clean/dirty misses, busy hold, reset mid-fill.
module tb_mem_stage_win;

   localparam int NCH = 3, DW = 16, TW = 5, AW = 25, WIN_LOG2 = 8;

   logic              ref_clk, rst;
   logic [NCH*DW-1:0] pt_data_in, pt_data_out;
   logic [NCH*TW-1:0] pt_tag_in, pt_tag_out;
   logic              ls_valid, ls_R_nW, stall;
   logic [AW-1:0]     ls_addr;
   logic [7:0]        ls_data, wb_data;
   logic [TW-1:0]     ls_tag, ls_tag_out;

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] got [0:255];

   mem_stage_win_if #(.AW(AW)) sdif ();

   mem_stage_win #(.NCH(NCH), .DW(DW), .TW(TW), .AW(AW), .WIN_LOG2(WIN_LOG2)) dut (
      .ref_clk     (ref_clk),
      .rst         (rst),
      .pt_data_in  (pt_data_in),
      .pt_tag_in   (pt_tag_in),
      .pt_data_out (pt_data_out),
      .pt_tag_out  (pt_tag_out),
      .ls_valid    (ls_valid),
      .ls_R_nW     (ls_R_nW),
      .ls_addr     (ls_addr),
      .ls_data     (ls_data),
      .ls_tag      (ls_tag),
      .ls_tag_out  (ls_tag_out),
      .wb_data     (wb_data),
      .stall       (stall),
      .sdif        (sdif)
   );

   initial ref_clk = 1'b0;
   always #5 ref_clk = ~ref_clk;

   task automatic step();
      @(posedge ref_clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_req(input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         settle();
         if (sdif.sd_req === 1'b1) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic do_fill(input logic [AW-1:0] exp_start, input logic [7:0] xr, input bit early_done);
      bit ok;
      wait_req(40, ok);
      check("fill_req_seen", 64'(ok), 1);
      check("fill_req_wr", 64'(sdif.sd_wr), 0);
      check("fill_start", 64'(sdif.sd_start_addr), 64'(exp_start));
      check("fill_len", 64'(sdif.sd_length), 256);
      step();
      settle();
      check("fill_req_once", 64'(sdif.sd_req), 0);
      check("bubble_tag", 64'(ls_tag_out), 0);
      for (int i = 0; i < 256; i++) begin
         sdif.sd_rd_valid = 1'b1;
         sdif.sd_rd_data  = 8'(i) ^ xr;
         sdif.sd_done     = early_done && (i == 100);
         step();
      end
      sdif.sd_rd_valid = 1'b0;
      sdif.sd_done     = 1'b0;
      check("fill_stall_hold", 64'(stall), 1);
      sdif.sd_done = 1'b1;
      step();
      sdif.sd_done = 1'b0;
   endtask

   initial begin
      bit ok;
      int reqs;
      rst = 1'b1; pt_data_in = '0; pt_tag_in = '0;
      ls_valid = 1'b0; ls_R_nW = 1'b0; ls_addr = '0; ls_data = '0; ls_tag = '0;
      sdif.sd_busy = 1'b0; sdif.sd_rd_valid = 1'b0; sdif.sd_rd_data = '0;
      sdif.sd_wr_ready = 1'b0; sdif.sd_done = 1'b0;
      step(); step();
      rst = 1'b0;
      settle();
      check("rst_pt_data", 64'(pt_data_out), 0);
      check("rst_pt_tag", 64'(pt_tag_out), 0);
      check("rst_wb_data", 64'(wb_data), 0);
      check("rst_ls_tag", 64'(ls_tag_out), 0);
      check("rst_stall", 64'(stall), 0);
      check("rst_sd_req", 64'(sdif.sd_req), 0);

      // pass-through
      pt_data_in = {16'hBEEF, 16'h0000, 16'h1234};
      pt_tag_in  = {5'd7, 5'd0, 5'd5};
      step();
      check("pt_data", 64'(pt_data_out), 64'h0000_BEEF_0000_1234);
      check("pt_tag", 64'(pt_tag_out), 64'({5'd7, 5'd0, 5'd5}));
      check("pt_stall", 64'(stall), 0);
      pt_data_in = '0; pt_tag_in = '0;

      // first load misses, clean fill with bytes equal to index
      ls_valid = 1'b1; ls_R_nW = 1'b1; ls_addr = 25'h000010; ls_tag = 5'd3;
      settle();
      check("miss_stall", 64'(stall), 1);
      check("miss_no_req_idle", 64'(sdif.sd_req), 0);
      do_fill(25'h000000, 8'h00, 1'b0);
      settle();
      check("fill1_stall_drop", 64'(stall), 0);
      step();
      check("load10_data", 64'(wb_data), 64'h10);
      check("load10_tag", 64'(ls_tag_out), 3);

      // store hit then load hit
      ls_R_nW = 1'b0; ls_addr = 25'h000020; ls_data = 8'hAB; ls_tag = 5'd9;
      settle();
      check("store_stall", 64'(stall), 0);
      step();
      check("store_tag", 64'(ls_tag_out), 0);
      ls_R_nW = 1'b1; ls_tag = 5'd4;
      settle();
      check("hit_no_req", 64'(sdif.sd_req), 0);
      step();
      check("load20_data", 64'(wb_data), 64'hAB);
      check("load20_tag", 64'(ls_tag_out), 4);

      // dirty miss with controller busy for 10 cycles
      sdif.sd_busy = 1'b1;
      ls_addr = 25'h000305; ls_tag = 5'd6;
      settle();
      check("dirty_miss_stall", 64'(stall), 1);
      reqs = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         settle();
         if (sdif.sd_req !== 1'b0) reqs++;
      end
      check("busy_no_req", 64'(reqs), 0);
      sdif.sd_busy = 1'b0;
      settle();
      check("wb_req", 64'(sdif.sd_req), 1);
      check("wb_req_wr", 64'(sdif.sd_wr), 1);
      check("wb_start", 64'(sdif.sd_start_addr), 0);
      step();
      settle();
      check("wb_req_once", 64'(sdif.sd_req), 0);
      for (int i = 0; i < 256; i++) begin
         got[i] = sdif.sd_wr_data;
         sdif.sd_wr_ready = 1'b1;
         step();
         settle();
      end
      sdif.sd_wr_ready = 1'b0;
      check("wb_stall", 64'(stall), 1);
      sdif.sd_done = 1'b1;
      step();
      sdif.sd_done = 1'b0;
      check("wb_byte00", 64'(got[8'h00]), 64'h00);
      check("wb_byte10", 64'(got[8'h10]), 64'h10);
      check("wb_byte20", 64'(got[8'h20]), 64'hAB);
      check("wb_byteFF", 64'(got[8'hFF]), 64'hFF);
      do_fill(25'h000300, 8'h5A, 1'b1);
      settle();
      check("fill2_stall_drop", 64'(stall), 0);
      step();
      check("load305_data", 64'(wb_data), 64'h5F);
      check("load305_tag", 64'(ls_tag_out), 6);

      // reset in the middle of a fill
      ls_addr = 25'h001000; ls_tag = 5'd2;
      wait_req(40, ok);
      check("rfill_req_seen", 64'(ok), 1);
      step();
      for (int i = 0; i < 10; i++) begin
         sdif.sd_rd_valid = 1'b1;
         sdif.sd_rd_data  = 8'(i);
         step();
      end
      sdif.sd_rd_valid = 1'b0;
      rst = 1'b1; ls_valid = 1'b0;
      step();
      rst = 1'b0;
      settle();
      check("rst_mid_stall", 64'(stall), 0);
      check("rst_mid_req", 64'(sdif.sd_req), 0);
      step();
      settle();
      check("rst_no_reissue", 64'(sdif.sd_req), 0);
      ls_valid = 1'b1;
      settle();
      check("post_rst_miss", 64'(stall), 1);
      do_fill(25'h001000, 8'hC3, 1'b0);
      settle();
      check("fill3_stall_drop", 64'(stall), 0);
      step();
      check("load1000_data", 64'(wb_data), 64'hC3);
      check("load1000_tag", 64'(ls_tag_out), 2);
      ls_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
